// File: rtl/boot_loader.sv
`default_nettype none
// ============================================================================
// Module   : boot_loader
// Brief    : Byte-stream program loader. Assembles big-endian 16-bit words
//            and writes them to instruction memory at consecutive even byte
//            addresses, holding the CPU in reset until the image is complete.
//            Optional checksum byte verification when BOOT_CHECKSUM_EN is
//            defined (running XOR of all data bytes, length byte excluded).
// Revision : 1.0 - initial release
// ============================================================================
module boot_loader #(
    parameter int DEPTH_WORDS = 128
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic        rx_valid,
    input  logic [7:0]  rx_data,
    output logic        rx_ready,
    output logic        im_we,
    output logic [7:0]  im_addr,
    output logic [15:0] im_wdata,
    output logic        cpu_reset,
    output logic        busy,
    output logic        done,
    output logic        err
);

    // Largest accepted length, widened by one bit so the compare cannot overflow
    localparam logic [8:0] C_MAX_LEN = 9'(DEPTH_WORDS);

`ifdef BOOT_CHECKSUM_EN
    typedef enum logic [2:0] {
        S_IDLE = 3'd0, S_LEN = 3'd1, S_HI = 3'd2, S_LO = 3'd3,
        S_WR   = 3'd4, S_CHK = 3'd5, S_DONE = 3'd6, S_ERR = 3'd7
    } state_t;
`else
    typedef enum logic [2:0] {
        S_IDLE = 3'd0, S_LEN = 3'd1, S_HI = 3'd2, S_LO = 3'd3,
        S_WR   = 3'd4, S_DONE = 3'd6, S_ERR = 3'd7
    } state_t;
`endif

    state_t     r_state;
    logic [7:0] r_len;
    logic [7:0] r_cnt;
    logic [7:0] w_cnt_next;
    logic       w_accept;
`ifdef BOOT_CHECKSUM_EN
    logic [7:0] r_csum;
`endif

    // rx_ready depends only on the state so nothing combinationally follows rx_valid
    always_comb begin
        rx_ready = 1'b0;
        case (r_state)
            S_LEN, S_HI, S_LO: rx_ready = 1'b1;
`ifdef BOOT_CHECKSUM_EN
            S_CHK:             rx_ready = 1'b1;
`endif
            default:           rx_ready = 1'b0;
        endcase
    end

    assign w_accept   = rx_valid && rx_ready;
    assign w_cnt_next = r_cnt + 8'd1;

    // Load sequencer: length byte, then HI/LO byte pairs each followed by one write cycle
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state   <= S_IDLE;
            r_len     <= 8'd0;
            r_cnt     <= 8'd0;
            im_we     <= 1'b0;
            im_addr   <= 8'h00;
            im_wdata  <= 16'h0000;
            cpu_reset <= 1'b1;
            busy      <= 1'b0;
            done      <= 1'b0;
            err       <= 1'b0;
`ifdef BOOT_CHECKSUM_EN
            r_csum    <= 8'h00;
`endif
        end else begin
            im_we <= 1'b0;
            case (r_state)
                S_IDLE, S_DONE, S_ERR: begin
                    if (start) begin
                        r_state   <= S_LEN;
                        im_addr   <= 8'h00;
                        r_cnt     <= 8'd0;
                        done      <= 1'b0;
                        err       <= 1'b0;
                        busy      <= 1'b1;
                        cpu_reset <= 1'b1;
`ifdef BOOT_CHECKSUM_EN
                        r_csum    <= 8'h00;
`endif
                    end
                end
                S_LEN: begin
                    if (w_accept) begin
                        if ((rx_data == 8'd0) || ({1'b0, rx_data} > C_MAX_LEN)) begin
                            r_state   <= S_ERR;
                            err       <= 1'b1;
                            busy      <= 1'b0;
                            cpu_reset <= 1'b1;
                        end else begin
                            r_len   <= rx_data;
                            r_state <= S_HI;
                        end
                    end
                end
                S_HI: begin
                    if (w_accept) begin
                        im_wdata[15:8] <= rx_data;
`ifdef BOOT_CHECKSUM_EN
                        r_csum         <= r_csum ^ rx_data;
`endif
                        r_state        <= S_LO;
                    end
                end
                S_LO: begin
                    if (w_accept) begin
                        im_wdata[7:0] <= rx_data;
`ifdef BOOT_CHECKSUM_EN
                        r_csum        <= r_csum ^ rx_data;
`endif
                        im_we         <= 1'b1;
                        r_state       <= S_WR;
                    end
                end
                S_WR: begin
                    im_addr <= im_addr + 8'd2;
                    r_cnt   <= w_cnt_next;
                    if (w_cnt_next == r_len) begin
`ifdef BOOT_CHECKSUM_EN
                        r_state   <= S_CHK;
`else
                        r_state   <= S_DONE;
                        done      <= 1'b1;
                        busy      <= 1'b0;
                        cpu_reset <= 1'b0;
`endif
                    end else begin
                        r_state <= S_HI;
                    end
                end
`ifdef BOOT_CHECKSUM_EN
                S_CHK: begin
                    if (w_accept) begin
                        busy <= 1'b0;
                        if (rx_data == r_csum) begin
                            r_state   <= S_DONE;
                            done      <= 1'b1;
                            cpu_reset <= 1'b0;
                        end else begin
                            r_state   <= S_ERR;
                            err       <= 1'b1;
                            cpu_reset <= 1'b1;
                        end
                    end
                end
`endif
                default: r_state <= S_IDLE;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_boot_loader.sv
`default_nettype none
// ============================================================================
// Module   : tb_boot_loader
// Brief    : Randomized scoreboard bench for boot_loader. Expected memory
//            writes are computed from the image bytes and queued; a monitor
//            pops and compares on every im_we. Load outcome and latency are
//            checked against a simple image-level model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_boot_loader;

    localparam int DEPTH = 128;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic        rx_valid;
    logic [7:0]  rx_data;
    logic        rx_ready;
    logic        im_we;
    logic [7:0]  im_addr;
    logic [15:0] im_wdata;
    logic        cpu_reset;
    logic        busy;
    logic        done;
    logic        err;

    int          vectors    = 0;
    int          miscompares = 0;
    int          cyc        = 0;
    logic [23:0] exp_q[$];
    logic [7:0]  img[$];

    boot_loader #(.DEPTH_WORDS(DEPTH)) dut (
        .clk(clk), .reset(reset), .start(start),
        .rx_valid(rx_valid), .rx_data(rx_data), .rx_ready(rx_ready),
        .im_we(im_we), .im_addr(im_addr), .im_wdata(im_wdata),
        .cpu_reset(cpu_reset), .busy(busy), .done(done), .err(err)
    );

    always #5 clk = ~clk;

    // Free-running cycle count for latency measurement
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // Scoreboard monitor: every write strobe must match the head of the queue
    initial begin
        logic [23:0] e;
        forever begin
            @(negedge clk);
            if (im_we === 1'b1) begin
                if (exp_q.size() == 0) begin
                    vectors++;
                    miscompares++;
                    $display("FAIL unexpected_write: addr 0x%0h data 0x%0h, none expected", im_addr, im_wdata);
                end else begin
                    e = exp_q.pop_front();
                    check("wr_addr", 32'(im_addr), 32'(e[23:16]));
                    check("wr_data", 32'(im_wdata), 32'(e[15:0]));
                    check("rx_ready_in_wr", 32'(rx_ready), 32'd0);
                end
            end
        end
    end

    // Offer one byte and hold it until the loader takes it
    task automatic send_byte(input logic [7:0] b);
        int t = 0;
        rx_valid = 1'b1;
        rx_data  = b;
        while (rx_ready !== 1'b1 && t < 50) begin
            @(negedge clk);
            t++;
        end
        if (t >= 50) check("send_timeout", 32'd1, 32'd0);
        @(posedge clk);
        #1;
        rx_valid = 1'b0;
    endtask

    task automatic pulse_start();
        @(negedge clk);
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    // Run one load of image 'img' with declared length n; model decides outcome
    task automatic do_load(input int n, input logic [7:0] chk, input int stall_idx, input bit timing);
        logic [7:0] x = 8'h00;
        bit len_ok, ok;
        int t0, k, exp_lat;
        foreach (img[i]) x ^= img[i];
        len_ok = (n >= 1) && (n <= DEPTH);
        ok = len_ok;
        exp_lat = 1 + 3 * n;
`ifdef BOOT_CHECKSUM_EN
        ok = ok && (chk == x);
        exp_lat = exp_lat + 1;
`endif
        if (len_ok)
            for (int w = 0; w < n; w++)
                exp_q.push_back({8'(2 * w), img[2*w], img[2*w+1]});
        pulse_start();
        t0 = cyc;
        check("start_busy", 32'(busy), 32'd1);
        check("start_rx_ready", 32'(rx_ready), 32'd1);
        check("start_cpu_reset", 32'(cpu_reset), 32'd1);
        send_byte(8'(n));
        if (len_ok) begin
            for (int i = 0; i < 2 * n; i++) begin
                if (i == stall_idx) begin
                    for (int s = 0; s < 5; s++) begin
                        @(negedge clk);
                        start = (s == 1);
                    end
                    start = 1'b0;
                    check("stall_start_ignored_busy", 32'(busy), 32'd1);
                    check("stall_start_ignored_done", 32'(done), 32'd0);
                end
                send_byte(img[i]);
            end
`ifdef BOOT_CHECKSUM_EN
            send_byte(chk);
`endif
        end
        k = 0;
        while (!(done === 1'b1 || err === 1'b1) && k < 1000) begin
            @(posedge clk);
            #1;
            k++;
        end
        if (k >= 1000) check("finish_timeout", 32'd1, 32'd0);
        check("done", 32'(done), 32'(ok));
        check("err", 32'(err), 32'(!ok));
        check("cpu_reset", 32'(cpu_reset), 32'(!ok));
        check("busy_end", 32'(busy), 32'd0);
        if (timing) check("latency", 32'(cyc - t0), 32'(exp_lat));
        check("writes_pending", 32'(exp_q.size()), 32'd0);
    endtask

    task automatic rand_img(input int n);
        img = {};
        for (int i = 0; i < 2 * n; i++) img.push_back(8'($urandom_range(0, 255)));
    endtask

    function automatic logic [7:0] img_xor();
        logic [7:0] x = 8'h00;
        foreach (img[i]) x ^= img[i];
        return x;
    endfunction

    initial begin
        int n, st;
        logic [7:0] c;
        reset = 1'b1; start = 1'b0; rx_valid = 1'b0; rx_data = 8'h00;
        repeat (3) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;

        // Reset state and idle hold
        check("rst_rx_ready", 32'(rx_ready), 32'd0);
        check("rst_cpu_reset", 32'(cpu_reset), 32'd1);
        check("rst_im_addr", 32'(im_addr), 32'd0);
        check("rst_im_wdata", 32'(im_wdata), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_err", 32'(err), 32'd0);
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            check("idle_no_we", 32'(im_we), 32'd0);
        end

        // Directed full-speed image 12 34 AB CD
        img = {8'h12, 8'h34, 8'hAB, 8'hCD};
        do_load(2, 8'h40, -1, 1'b1);
        do_load(2, 8'h41, -1, 1'b1);

        // Illegal lengths
        img = {};
        do_load(0, 8'h00, -1, 1'b0);
        do_load(8'h81, 8'h00, -1, 1'b0);

        // Stall between HI and LO with a start pulse in the gap
        rand_img(3);
        do_load(3, img_xor(), 3, 1'b0);

        // Reset while in LO after a HI byte
        pulse_start();
        send_byte(8'd1);
        send_byte(8'h55);
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        check("midrst_rx_ready", 32'(rx_ready), 32'd0);
        check("midrst_busy", 32'(busy), 32'd0);
        check("midrst_cpu_reset", 32'(cpu_reset), 32'd1);
        check("midrst_im_addr", 32'(im_addr), 32'd0);
        check("midrst_im_wdata", 32'(im_wdata), 32'd0);
        check("midrst_done_err", 32'({done, err}), 32'd0);
        img = {8'h55, 8'h66};
        do_load(1, 8'h33, -1, 1'b1);

        // Randomized loads
        for (int r = 0; r < 10; r++) begin
            n = $urandom_range(1, 6);
            rand_img(n);
            c = img_xor() ^ (($urandom_range(0, 3) == 0) ? 8'h01 : 8'h00);
            st = ($urandom_range(0, 1) == 1) ? int'($urandom_range(0, 2 * n - 1)) : -1;
            do_load(n, c, st, st < 0);
        end

        // Capacity boundary: full memory, last address 0xFE
        rand_img(DEPTH);
        do_load(DEPTH, img_xor(), -1, 1'b1);

        repeat (3) @(posedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
`default_nettype wire
